// File: rtl/shift_fifo_pkg.sv
// shift_fifo_pkg
// Shared constants and helpers for the shift-register FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and stage count
//   count_width(depth)            : bits needed to hold an occupancy of 0..depth
package shift_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_fifo_stage.sv
// shift_fifo_stage
// One storage stage of the shift chain: a WIDTH-bit register that loads d
// when en is high and clears asynchronously while rst_n is low.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear
//   en    : load enable
//   d     : word to load
//   q     : stored word
module shift_fifo_stage
    import shift_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shift_fifo.sv
// shift_fifo
// FIFO built from a DEPTH-stage shift chain. New words always enter stage 0
// and every accepted push shifts the whole chain; the oldest word therefore
// sits at stage[count-1] and a pop only has to shrink count.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (clears storage and count)
//   push      : write request
//   pop       : read request
//   data_in   : word written on an accepted push
//   data_out  : oldest stored word (zero when empty), combinational
//   count     : current occupancy, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, push while full without pop   (SHIFT_FIFO_ERR_EN only)
//   underflow : sticky, pop while empty                (SHIFT_FIFO_ERR_EN only)
// Configuration macro: SHIFT_FIFO_ERR_EN adds the overflow/underflow flags.
module shift_fifo
    import shift_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [count_width(DEPTH)-1:0] count,
`ifdef SHIFT_FIFO_ERR_EN
    output logic                          overflow,
    output logic                          underflow,
`endif
    output logic                          full,
    output logic                          empty
);

    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic             push_acc;
    logic             pop_acc;
    logic [CW-1:0]    count_next;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push while full is still taken when paired with a pop: the word
    // shifted out of the last stage is exactly the one being popped.
    assign push_acc = push && (!full || pop);
    assign pop_acc  = pop && !empty;

    always_comb begin
        count_next = count + CW'(push_acc) - CW'(pop_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d;
        if (k == 0) begin : g_first
            assign d = data_in;
        end else begin : g_next
            assign d = stage_q[k-1];
        end
        shift_fifo_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (push_acc),
            .d    (d),
            .q    (stage_q[k])
        );
    end

    // Oldest word lives at stage[count-1]; no match leaves the output zero.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) begin
                data_out = stage_q[i];
            end
        end
    end

`ifdef SHIFT_FIFO_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !pop && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_fifo.sv
// tb_shift_fifo
// Self-checking bench for shift_fifo (WIDTH=8, DEPTH=4). Stimulus updates a
// queue-based reference model and pushes the expected output snapshot into
// a scoreboard; an independent monitor pops and compares against the DUT.
// Honours SHIFT_FIFO_ERR_EN for the overflow/underflow flags.
module tb_shift_fifo;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic         push;
    logic         pop;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic [2:0]   count;
    logic         full;
    logic         empty;
`ifdef SHIFT_FIFO_ERR_EN
    logic         overflow;
    logic         underflow;
`endif

    shift_fifo #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .count    (count),
`ifdef SHIFT_FIFO_ERR_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .full     (full),
        .empty    (empty)
    );

    typedef struct {
        int           id;
        logic [W-1:0] data;
        logic [2:0]   cnt;
        logic         full;
        logic         empty;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_q[$];
    logic         model_ovf;
    logic         model_unf;
    int           next_id;
    int           vectors;
    int           miscompares;
    event         check_ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs derived purely from the model queue contents.
    function automatic exp_t snapshot();
        exp_t e;
        e.id    = next_id;
        e.data  = (model_q.size() > 0) ? model_q[0] : '0;
        e.cnt   = 3'(model_q.size());
        e.full  = (model_q.size() == D);
        e.empty = (model_q.size() == 0);
        e.ovf   = model_ovf;
        e.unf   = model_unf;
        return e;
    endfunction

    task automatic compareField(input string name, input int id,
                                input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s (check %0d): got 0x%0h, expected 0x%0h",
                     name, id, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("data_out", e.id, 64'(data_out), 64'(e.data));
        compareField("count",    e.id, 64'(count),    64'(e.cnt));
        compareField("full",     e.id, 64'(full),     64'(e.full));
        compareField("empty",    e.id, 64'(empty),    64'(e.empty));
`ifdef SHIFT_FIFO_ERR_EN
        compareField("overflow",  e.id, 64'(overflow),  64'(e.ovf));
        compareField("underflow", e.id, 64'(underflow), 64'(e.unf));
`endif
    endtask

    // Monitor: drains the scoreboard on each falling edge, or immediately
    // when stimulus requests a check between edges (async reset).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or check_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic requestCheck();
        exp_q.push_back(snapshot());
        next_id++;
        -> check_ev;
    endtask

    // One clock of stimulus; the model follows the FIFO rules directly.
    task automatic applyStimulus(input logic p, input logic po, input logic [W-1:0] d);
        logic [W-1:0] tmp;
        int sz;
        push    = p;
        pop     = po;
        data_in = d;
        @(posedge clk);
        sz = model_q.size();
        if (p && po) begin
            if (sz == 0) begin
                model_q.push_back(d);
                model_unf = 1'b1;
            end else begin
                tmp = model_q.pop_front();
                model_q.push_back(d);
            end
        end else if (p) begin
            if (sz < D) model_q.push_back(d);
            else        model_ovf = 1'b1;
        end else if (po) begin
            if (sz > 0) tmp = model_q.pop_front();
            else        model_unf = 1'b1;
        end
        exp_q.push_back(snapshot());
        next_id++;
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Reset pulse entirely inside the low clock phase; checked while low.
    task automatic resetPulse();
        #1 rst_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        requestCheck();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        model_ovf   = 1'b0;
        model_unf   = 1'b0;
        next_id     = 0;
        vectors     = 0;
        miscompares = 0;

        #2 requestCheck();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle
        applyStimulus(1'b0, 1'b0, 8'h00);
        // Fill, then overflow attempt
        applyStimulus(1'b1, 1'b0, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h22);
        applyStimulus(1'b1, 1'b0, 8'h33);
        applyStimulus(1'b1, 1'b0, 8'h44);
        applyStimulus(1'b1, 1'b0, 8'h55);
        // Drain, then underflow attempt
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        // Simultaneous push/pop mid-occupancy and when full
        applyStimulus(1'b1, 1'b0, 8'hA1);
        applyStimulus(1'b1, 1'b0, 8'hB2);
        applyStimulus(1'b1, 1'b1, 8'hC3);
        applyStimulus(1'b1, 1'b0, 8'hD4);
        applyStimulus(1'b1, 1'b0, 8'hE5);
        applyStimulus(1'b1, 1'b1, 8'h66);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        // Push with pop while empty
        applyStimulus(1'b1, 1'b1, 8'h7E);
        // Reach count 3, async reset mid-cycle, then restart
        applyStimulus(1'b1, 1'b0, 8'h12);
        applyStimulus(1'b1, 1'b0, 8'h34);
        resetPulse();
        applyStimulus(1'b1, 1'b0, 8'h99);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                resetPulse();
            end
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                          W'($urandom));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
